// File: rtl/iob_axis_s_axi_m_read_sched.sv
// rtl/iob_axis_s_axi_m_read_sched.sv - round-robin job scheduler sharing one AXI-read-to-stream DMA
// Grants one (addr, len) job at a time, launches the DMA, counts stream beats, reports completion.
module iob_axis_s_axi_m_read_sched #(
  parameter int N_REQ      = 2,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int RLEN_W     = 16,
  localparam int OWN_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        cke_i,
  input  logic                        arst_n_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*AXI_ADDR_W-1:0] req_addr_i,
  input  logic [N_REQ*RLEN_W-1:0]     req_len_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [N_REQ-1:0]            req_done_o,
  output logic [OWN_W-1:0]            owner_o,
  output logic                        busy_o,
  input  logic [AXI_LEN_W:0]          max_len_i,
  output logic [AXI_ADDR_W-1:0]       r_addr_o,
  output logic [RLEN_W-1:0]           r_length_o,
  output logic [AXI_LEN_W:0]          r_max_len_o,
  output logic                        r_start_transfer_o,
  input  logic                        r_busy_i,
  input  logic [RLEN_W-1:0]           r_remaining_data_i,
  input  logic                        axis_tvalid_i,
  input  logic                        axis_tready_i
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [OWN_W-1:0]      owner_q, owner_d;
  logic [OWN_W-1:0]      last_q, last_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [RLEN_W-1:0]     len_q, len_d;
  logic [RLEN_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [AXI_LEN_W:0]    max_len_q, max_len_d;

  logic [OWN_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [RLEN_W-1:0]     pick_len;
  logic [AXI_ADDR_W-1:0] pick_addr;
  logic                  act;
  logic                  unused_remaining;

  // Pulses must not be offered while the registers cannot take the transition.
  assign act              = cke_i & arst_n_i;
  assign unused_remaining = ^r_remaining_data_i;

  // First valid requester after the last grant, wrapping around.
  always_comb begin : rr_pick
    int idx;
    idx        = 0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_found && req_valid_i[idx]) begin
        pick_found = 1'b1;
        pick_idx   = OWN_W'(idx);
      end
    end
  end

  assign pick_len  = req_len_i[int'(pick_idx)*RLEN_W +: RLEN_W];
  assign pick_addr = req_addr_i[int'(pick_idx)*AXI_ADDR_W +: AXI_ADDR_W];

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    last_d             = last_q;
    addr_d             = addr_q;
    len_d              = len_q;
    max_len_d          = max_len_q;
    beat_cnt_d         = beat_cnt_q;
    req_ready_o        = '0;
    req_done_o         = '0;
    r_start_transfer_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          req_ready_o[pick_idx] = act;
          addr_d                = pick_addr;
          len_d                 = pick_len;
          max_len_d             = max_len_i;
          owner_d               = pick_idx;
          last_d                = pick_idx;
          state_d               = (pick_len == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!r_busy_i) begin
          r_start_transfer_o = cke_i;
          beat_cnt_d         = '0;
          state_d            = S_WAIT;
        end
      end
      S_WAIT: begin
        // Saturate at the job length so trailing handshakes cannot wrap the count.
        if (axis_tvalid_i && axis_tready_i && (beat_cnt_q != len_q))
          beat_cnt_d = beat_cnt_q + 1'b1;
        if ((beat_cnt_q == len_q) && !r_busy_i)
          state_d = S_DONE;
      end
      S_DONE: begin
        req_done_o[owner_q] = cke_i;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      last_q     <= OWN_W'(N_REQ - 1);
      addr_q     <= '0;
      len_q      <= '0;
      max_len_q  <= '0;
      beat_cnt_q <= '0;
    end else if (cke_i) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      max_len_q  <= max_len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign owner_o     = owner_q;
  assign busy_o      = (state_q != S_IDLE);
  assign r_addr_o    = addr_q;
  assign r_length_o  = len_q;
  assign r_max_len_o = max_len_q;

endmodule
